// File: rtl/polyveck_reduce_stream.sv
// -----------------------------------------------------------------------------
// polyveck_reduce_stream
//
// Streams one K-polynomial vector of N signed 32-bit coefficients, LANES
// coefficients per beat, through a 2-stage reduction pipeline. The mode
// (reduce32 / caddq / freeze / bypass) is latched when a vector starts.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, mode       begin a vector (sampled in IDLE), mode latched at start
//   busy, done        busy in RUN/DRAIN; done pulses once after the last beat
//   in_valid/ready    input handshake, in_data carries LANES x 32-bit lanes
//   out_valid/ready   output handshake, out_data same lane order as in_data
//   out_last          final beat of the vector
//   out_poly/out_coef polynomial index / lane-0 coefficient index of the beat
// -----------------------------------------------------------------------------
module polyveck_reduce_stream #(
   parameter int K     = 6,
   parameter int N     = 256,
   parameter int LANES = 4,
   parameter int Q     = 8380417,
   localparam int PW   = (K > 1) ? $clog2(K) : 1,
   localparam int CW   = (N > 1) ? $clog2(N) : 1,
   localparam int DW   = 32 * LANES
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [1:0]    mode,
   output logic          busy,
   output logic          done,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic [PW-1:0] out_poly,
   output logic [CW-1:0] out_coef
);

   localparam logic [31:0] QV = 32'(Q);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_n_s;
   logic [1:0]        mode_r;
   logic [PW-1:0]     in_poly_r;
   logic [CW-1:0]     in_coef_r;
   logic              in_last_s;
   logic              in_fire_s;
   logic              in_ready_s;
   logic              start_acc_s;
   logic              s1_adv_s;
   logic              s1_load_s;
   logic              out_fire_s;
   logic              done_r;

   logic              s1_valid_r;
   logic [DW-1:0]     s1_a_r;
   logic [LANES*10-1:0] s1_t_r;
   logic [PW-1:0]     s1_poly_r;
   logic [CW-1:0]     s1_coef_r;
   logic              s1_last_r;
   logic [LANES*10-1:0] t_s;
   logic [DW-1:0]     res_s;

   logic              out_valid_r;
   logic [DW-1:0]     out_data_r;
   logic              out_last_r;
   logic [PW-1:0]     out_poly_r;
   logic [CW-1:0]     out_coef_r;

   // Stage-2 lane function: t has already been rounded in stage 1, so only the
   // multiply-subtract and the conditional +Q remain here.
   function automatic logic [31:0] lane_result(input logic [1:0]  m,
                                               input logic [31:0] a,
                                               input logic [9:0]  t);
      logic [31:0] tq;
      logic [31:0] r;
      logic [31:0] res;
      tq = {{22{t[9]}}, t} * QV;
      r  = a - tq;
      case (m)
         2'd0:    res = r;
         2'd1:    res = a + (a[31] ? QV : 32'd0);
         2'd2:    res = r + (r[31] ? QV : 32'd0);
         2'd3:    res = a;
         default: res = a;
      endcase
      return res;
   endfunction

   assign s1_adv_s   = !out_valid_r || out_ready;
   assign s1_load_s  = !s1_valid_r || s1_adv_s;
   assign in_fire_s  = in_valid && in_ready_s;
   assign out_fire_s = out_valid_r && out_ready;
   assign in_last_s  = (in_poly_r == PW'(K - 1)) && (in_coef_r == CW'(N - LANES));

   assign busy      = (state_r == RUN) || (state_r == DRAIN);
   assign done      = done_r;
   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_last  = out_last_r;
   assign out_poly  = out_poly_r;
   assign out_coef  = out_coef_r;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_n_s;
      end
   end

   // Next-state logic and input-side handshake.
   always_comb begin
      state_n_s   = state_r;
      in_ready_s  = 1'b0;
      start_acc_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_n_s   = RUN;
               start_acc_s = 1'b1;
            end else begin
               state_n_s = IDLE;
            end
         end
         RUN: begin
            in_ready_s = s1_load_s;
            if (in_valid && s1_load_s && in_last_s) begin
               state_n_s = DRAIN;
            end else begin
               state_n_s = RUN;
            end
         end
         DRAIN: begin
            if (out_fire_s && out_last_r) begin
               state_n_s = IDLE;
            end else begin
               state_n_s = DRAIN;
            end
         end
         default: begin
            state_n_s = IDLE;
         end
      endcase
   end

   // Mode latch, input beat counters and done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_r    <= 2'd0;
         in_poly_r <= '0;
         in_coef_r <= '0;
         done_r    <= 1'b0;
      end else begin
         done_r <= (state_r == DRAIN) && out_fire_s && out_last_r;
         if (start_acc_s) begin
            mode_r    <= mode;
            in_poly_r <= '0;
            in_coef_r <= '0;
         end else if (in_fire_s) begin
            if (in_coef_r == CW'(N - LANES)) begin
               in_coef_r <= '0;
               in_poly_r <= in_last_s ? '0 : in_poly_r + PW'(1);
            end else begin
               in_coef_r <= in_coef_r + CW'(LANES);
            end
         end
      end
   end

   // Stage-1 rounding: t = (a + 2^22) >>> 23 in 33 bits; bits [32:23] of the
   // 33-bit sum are exactly the signed 10-bit quotient.
   always_comb begin
      t_s = '0;
      for (int l = 0; l < LANES; l++) begin
         logic [32:0] a33;
         a33 = {in_data[32*l+31], in_data[32*l +: 32]} + 33'd4194304;
         t_s[10*l +: 10] = a33[32:23];
      end
   end

   // Stage-2 lane results from the stage-1 register.
   always_comb begin
      res_s = '0;
      for (int l = 0; l < LANES; l++) begin
         res_s[32*l +: 32] = lane_result(mode_r, s1_a_r[32*l +: 32], s1_t_r[10*l +: 10]);
      end
   end

   // Two-stage pipeline; s2 is the output register and holds under backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r  <= 1'b0;
         s1_a_r      <= '0;
         s1_t_r      <= '0;
         s1_poly_r   <= '0;
         s1_coef_r   <= '0;
         s1_last_r   <= 1'b0;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_last_r  <= 1'b0;
         out_poly_r  <= '0;
         out_coef_r  <= '0;
      end else begin
         if (s1_load_s) begin
            s1_valid_r <= in_fire_s;
            if (in_fire_s) begin
               s1_a_r    <= in_data;
               s1_t_r    <= t_s;
               s1_poly_r <= in_poly_r;
               s1_coef_r <= in_coef_r;
               s1_last_r <= in_last_s;
            end
         end
         if (s1_adv_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
               out_data_r <= res_s;
               out_poly_r <= s1_poly_r;
               out_coef_r <= s1_coef_r;
               out_last_r <= s1_last_r;
            end
         end
      end
   end

endmodule
